// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants and types used by the writeback arbiter slice.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 2 ** REG_AW;

  // Requester indices into the arbiter valid/grant vectors.
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the two requesters (ALU = req0, load unit = req1).
//
// Handshake: a requester raises reqN_valid with reqN_rd/reqN_data stable and
// keeps them stable until it sees reqN_ready=1. A transfer happens on the
// rising clock edge where valid and ready are both 1. Ready is combinational
// from the valids and the round-robin state and never depends on the other
// requester's ready.
interface regfile_wb_arbiter_if;
  import cpu_pkg::*;

  logic      req0_valid;
  logic      req0_ready;
  reg_idx_t  req0_rd;
  reg_data_t req0_data;

  logic      req1_valid;
  logic      req1_ready;
  reg_idx_t  req1_rd;
  reg_data_t req1_data;

  // Requester side (execute/memory stages).
  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. rr_last remembers the most recently
// accepted requester; on a tie the other one is granted.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       rr_last
);

  logic rr_last_q;
  logic rr_last_d;

  // Grant selection: single requester wins outright, tie goes to the one not served last.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // rr_last only moves when a grant is actually taken.
  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) begin
      rr_last_d = grant[REQ_LSU];
    end
  end

  // Reset to 1 so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the ALU and the load unit, registers
// the winning write, and tracks pending destination registers to stall decode.
module regfile_wb_arbiter
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   req,
  input  logic                  iss_valid,
  input  reg_idx_t              iss_rd,
  input  reg_idx_t              rs1_sel,
  input  reg_idx_t              rs2_sel,
  output logic                  stall,
  output logic                  wb_wen,
  output reg_idx_t              wb_dsel,
  output reg_data_t             wb_d,
  output logic [NREG-1:0]       pend_mask
);

  logic [1:0] arb_valid;
  logic [1:0] grant;
  logic       accept;
  logic       rr_last;

  reg_idx_t   acc_rd;
  reg_data_t  acc_data;

  logic       wb_wen_q,  wb_wen_d;
  reg_idx_t   wb_dsel_q, wb_dsel_d;
  reg_data_t  wb_d_q,    wb_d_d;
  logic [NREG-1:0] pend_q, pend_d;

  assign arb_valid[REQ_ALU] = req.req0_valid;
  assign arb_valid[REQ_LSU] = req.req1_valid;

  // A grant always goes to a valid requester, so any grant is an accept.
  assign accept = |grant;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (arb_valid),
    .accept  (accept),
    .grant   (grant),
    .rr_last (rr_last)
  );

  assign req.req0_ready = grant[REQ_ALU];
  assign req.req1_ready = grant[REQ_LSU];

  // Select the accepted requester's destination and data.
  always_comb begin
    acc_rd   = req.req0_rd;
    acc_data = req.req0_data;
    if (grant[REQ_LSU]) begin
      acc_rd   = req.req1_rd;
      acc_data = req.req1_data;
    end
  end

  // Writeback register next state: load on accept, x0 writes are swallowed.
  always_comb begin
    wb_wen_d  = 1'b0;
    wb_dsel_d = wb_dsel_q;
    wb_d_d    = wb_d_q;
    if (accept) begin
      wb_wen_d  = (acc_rd != '0);
      wb_dsel_d = acc_rd;
      wb_d_d    = acc_data;
    end
  end

  // Scoreboard next state: clear on commit first, then a same-register issue re-sets it.
  always_comb begin
    pend_d = pend_q;
    if (wb_wen_q) begin
      pend_d[wb_dsel_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Writeback and scoreboard state; reset drops any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wen_q  <= 1'b0;
      wb_dsel_q <= '0;
      wb_d_q    <= '0;
      pend_q    <= '0;
    end else begin
      wb_wen_q  <= wb_wen_d;
      wb_dsel_q <= wb_dsel_d;
      wb_d_q    <= wb_d_d;
      pend_q    <= pend_d;
    end
  end

  assign wb_wen    = wb_wen_q;
  assign wb_dsel   = wb_dsel_q;
  assign wb_d      = wb_d_q;
  assign pend_mask = pend_q;
  assign stall     = pend_q[rs1_sel] | pend_q[rs2_sel];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for the writeback arbiter and scoreboard.
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  regfile_wb_arbiter_if bus ();

  logic            iss_valid;
  reg_idx_t        iss_rd;
  reg_idx_t        rs1_sel;
  reg_idx_t        rs2_sel;
  logic            stall;
  logic            wb_wen;
  reg_idx_t        wb_dsel;
  reg_data_t       wb_d;
  logic [NREG-1:0] pend_mask;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_sel   (rs1_sel),
    .rs2_sel   (rs2_sel),
    .stall     (stall),
    .wb_wen    (wb_wen),
    .wb_dsel   (wb_dsel),
    .wb_d      (wb_d),
    .pend_mask (pend_mask)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [REG_AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_stall;
    logic        e_wen;
    logic [4:0]  e_dsel;
    logic [31:0] e_d;
    logic [31:0] e_pend;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl[NVEC];

  function automatic vec_t mk(
    input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
    input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
    input logic iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
    input logic r0, input logic r1, input logic st,
    input logic wen, input logic [4:0] dsel, input logic [31:0] d, input logic [31:0] pend);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
    v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
    v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_stall = st;
    v.e_wen = wen; v.e_dsel = dsel; v.e_d = d; v.e_pend = pend;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1_sel = '0; rs2_sel = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.req0_valid = v.v0; bus.req0_rd = v.rd0; bus.req0_data = v.d0;
    bus.req1_valid = v.v1; bus.req1_rd = v.rd1; bus.req1_data = v.d1;
    iss_valid = v.iv; iss_rd = v.ird; rs1_sel = v.s1; rs2_sel = v.s2;
  endtask

  task automatic chk_regs(input string tag, input logic wen, input logic [4:0] dsel,
                          input logic [31:0] d, input logic [31:0] pend);
    chk({tag, ".wb_wen"},    {31'd0, wb_wen},  {31'd0, wen});
    chk({tag, ".wb_dsel"},   {27'd0, wb_dsel}, {27'd0, dsel});
    chk({tag, ".wb_d"},      wb_d,             d);
    chk({tag, ".pend_mask"}, pend_mask,        pend);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: ALU alone, then idle
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          0, 0, 0, 0, 1, 0, 0, 1, 5,  32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 5,  32'hDEADBEEF, 32'h0);
    // 3: load to x0 is consumed without a write, leaves rr_last on the load unit
    tbl[2]  = mk(0, 0, 0,            1, 0, 32'h1234,   0, 0, 0, 0, 0, 1, 0, 0, 0,  32'h1234,     32'h0);
    // 2: sustained tie alternates 0,1,0,1 starting with the ALU
    tbl[3]  = mk(1, 1, 32'hA01,      1, 9,  32'hB09,   0, 0, 0, 0, 1, 0, 0, 1, 1,  32'hA01,      32'h0);
    tbl[4]  = mk(1, 2, 32'hA02,      1, 9,  32'hB09,   0, 0, 0, 0, 0, 1, 0, 1, 9,  32'hB09,      32'h0);
    tbl[5]  = mk(1, 2, 32'hA02,      1, 10, 32'hB0A,   0, 0, 0, 0, 1, 0, 0, 1, 2,  32'hA02,      32'h0);
    tbl[6]  = mk(1, 3, 32'hA03,      1, 10, 32'hB0A,   0, 0, 0, 0, 0, 1, 0, 1, 10, 32'hB0A,      32'h0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 10, 32'hB0A,      32'h0);
    // 4: issue r7, stall on rs2, commit clears it
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,          1, 7, 0, 7, 0, 0, 0, 0, 10, 32'hB0A,      32'h80);
    tbl[9]  = mk(1, 7, 32'h77,       0, 0, 0,          0, 0, 0, 7, 1, 0, 1, 1, 7,  32'h77,       32'h80);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 7, 0, 0, 1, 0, 7,  32'h77,       32'h0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,          0, 0, 0, 7, 0, 0, 0, 0, 7,  32'h77,       32'h0);
    // 5: re-issue of r7 on the commit edge of r7 keeps it pending
    tbl[12] = mk(1, 7, 32'h707,      0, 0, 0,          1, 7, 0, 0, 1, 0, 0, 1, 7,  32'h707,      32'h80);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,          1, 7, 7, 0, 0, 0, 1, 0, 7,  32'h707,      32'h80);
    // issue to x0 never sets a bit; select 0 never stalls
    tbl[14] = mk(0, 0, 0,            0, 0, 0,          1, 0, 0, 7, 0, 0, 1, 0, 7,  32'h707,      32'h80);
    // set up wb_wen=1 and pend_mask=0x82 with rr_last on the ALU
    tbl[15] = mk(1, 3, 32'h33,       0, 0, 0,          1, 1, 0, 0, 1, 0, 0, 1, 3,  32'h33,       32'h82);

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 1'b0, 5'd0, 32'h0, 32'h0);
    chk("reset.req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    chk("reset.req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive_vec(tbl[i]);
      if (i == 3) begin
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd9);
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd10);
      end
      @(negedge clk);
      chk({tag, ".req0_ready"}, {31'd0, bus.req0_ready}, {31'd0, tbl[i].e_rdy0});
      chk({tag, ".req1_ready"}, {31'd0, bus.req1_ready}, {31'd0, tbl[i].e_rdy1});
      chk({tag, ".stall"},      {31'd0, stall},          {31'd0, tbl[i].e_stall});
      @(posedge clk);
      #1;
      chk_regs(tag, tbl[i].e_wen, tbl[i].e_dsel, tbl[i].e_d, tbl[i].e_pend);
      if (i >= 3 && i <= 6) begin
        logic [REG_AW-1:0] e;
        if (exp_q.size() == 0) begin
          chk({tag, ".order_q_empty"}, 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk({tag, ".commit_order"}, {27'd0, wb_dsel}, {27'd0, e});
        end
      end
    end
    chk("commit_order.drained", exp_q.size(), 32'd0);

    // 6: asynchronous reset mid-cycle while a write is in flight
    drive_idle();
    rs1_sel = 5'd1;
    rs2_sel = 5'd7;
    #1;
    chk("pre_reset.stall", {31'd0, stall}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_regs("async_reset", 1'b0, 5'd0, 32'h0, 32'h0);
    chk("async_reset.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd4;  bus.req0_data = 32'h44;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd12; bus.req1_data = 32'hCC;
    @(negedge clk);
    chk("post_reset.req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    chk("post_reset.req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk_regs("post_reset", 1'b1, 5'd4, 32'h44, 32'h0);
    drive_idle();
    @(posedge clk);
    #1;
    chk("post_reset.idle_wen", {31'd0, wb_wen}, 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
